// File: rtl/axi_lite_perip_bridge_if.sv
// AXI4-Lite data-side channel between the core initiator (master) and the peripheral bridge (slave).
interface axi_lite_perip_bridge_if;
    logic [31:0] s_araddr;
    logic        s_arvalid;
    logic        s_arready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rvalid;
    logic        s_rready;
    logic [31:0] s_awaddr;
    logic        s_awvalid;
    logic        s_awready;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_wvalid;
    logic        s_wready;
    logic [1:0]  s_bresp;
    logic        s_bvalid;
    logic        s_bready;

    modport master (
        output s_araddr, s_arvalid, s_rready, s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
        input  s_arready, s_rdata, s_rresp, s_rvalid, s_awready, s_wready, s_bresp, s_bvalid
    );

    modport slave (
        input  s_araddr, s_arvalid, s_rready, s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
        output s_arready, s_rdata, s_rresp, s_rvalid, s_awready, s_wready, s_bresp, s_bvalid
    );
endinterface

// File: rtl/axi_lite_perip_bridge.sv
// AXI4-Lite responder onto the flat peripheral bus, one transaction at a time; write: perip_wen at T+1, bvalid T+2;
// read: rvalid at T+2+READ_LATENCY. rvalid/bvalid hold until accepted; readies only in IDLE, write wins over read.
module axi_lite_perip_bridge #(
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    axi_lite_perip_bridge_if.slave  s_axi,
    output logic [31:0]             perip_addr,
    output logic                    perip_wen,
    output logic [1:0]              perip_mask,
    output logic [31:0]             perip_wdata,
    input  logic [31:0]             perip_rdata
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_WAIT = 3'd1,
        S_RD_RESP = 3'd2,
        S_WR_EXEC = 3'd3,
        S_WR_RESP = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic [3:0]  r_strb;
    logic [2:0]  r_cnt;
    logic [1:0]  r_bresp;
    logic        w_wr_req;
    logic [1:0]  w_mask;

    // Size mask for a strobe/offset pair; 2'b11 marks an unsupported combination.
    function automatic logic [1:0] f_mask(input logic [3:0] strb, input logic [1:0] off);
        logic [1:0] m;
        case ({strb, off})
            6'b0001_00, 6'b0010_01, 6'b0100_10, 6'b1000_11: m = 2'b00;
            6'b0011_00, 6'b1100_10:                         m = 2'b01;
            6'b1111_00:                                     m = 2'b10;
            default:                                        m = 2'b11;
        endcase
        return m;
    endfunction

    assign w_wr_req = s_axi.s_awvalid & s_axi.s_wvalid;
    assign w_mask   = f_mask(r_strb, r_addr[1:0]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_wr_req)             w_next = S_WR_EXEC;
                else if (s_axi.s_arvalid) w_next = S_RD_WAIT;
            end
            S_RD_WAIT: if (r_cnt == 3'd0)  w_next = S_RD_RESP;
            S_RD_RESP: if (s_axi.s_rready) w_next = S_IDLE;
            S_WR_EXEC:                     w_next = S_WR_RESP;
            S_WR_RESP: if (s_axi.s_bready) w_next = S_IDLE;
            default:                       w_next = S_IDLE;
        endcase
    end

    // Readies are gated by rst so that reset forces every s_* output low immediately.
    always_comb begin
        s_axi.s_arready = 1'b0;
        s_axi.s_awready = 1'b0;
        s_axi.s_wready  = 1'b0;
        s_axi.s_rvalid  = 1'b0;
        s_axi.s_bvalid  = 1'b0;
        perip_wen       = 1'b0;
        perip_mask      = 2'b11;
        case (r_state)
            S_IDLE: begin
                s_axi.s_awready = w_wr_req & ~rst;
                s_axi.s_wready  = w_wr_req & ~rst;
                s_axi.s_arready = ~w_wr_req & ~rst;
            end
            S_RD_RESP: s_axi.s_rvalid = 1'b1;
            S_WR_EXEC: begin
                perip_mask = w_mask;
                perip_wen  = (w_mask != 2'b11);
            end
            S_WR_RESP: s_axi.s_bvalid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_rdata <= 32'd0;
            r_strb  <= 4'd0;
            r_cnt   <= 3'd0;
            r_bresp <= 2'b00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_wr_req) begin
                        r_addr  <= s_axi.s_awaddr;
                        r_wdata <= s_axi.s_wdata >> {s_axi.s_awaddr[1:0], 3'b000};
                        r_strb  <= s_axi.s_wstrb;
                    end else if (s_axi.s_arvalid) begin
                        r_addr <= s_axi.s_araddr;
                        r_cnt  <= 3'(READ_LATENCY);
                    end
                end
                S_RD_WAIT: begin
                    if (r_cnt == 3'd0) r_rdata <= perip_rdata;
                    else               r_cnt   <= r_cnt - 3'd1;
                end
                S_WR_EXEC: r_bresp <= (w_mask == 2'b11) ? 2'b10 : 2'b00;
                default: ;
            endcase
        end
    end

    assign perip_addr    = r_addr;
    assign perip_wdata   = r_wdata;
    assign s_axi.s_rdata = r_rdata;
    assign s_axi.s_rresp = 2'b00;
    assign s_axi.s_bresp = r_bresp;

endmodule

// File: tb/tb_axi_lite_perip_bridge.sv
// Directed bench: write vector table on the READ_LATENCY=1 instance, reads on latency 0/1/3 instances, reset corners.
module tb_axi_lite_perip_bridge;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    axi_lite_perip_bridge_if bus0 ();
    axi_lite_perip_bridge_if bus1 ();
    axi_lite_perip_bridge_if bus3 ();

    // Read-side controls/observations indexed 0: latency 0, 1: latency 1, 2: latency 3.
    logic [2:0]        arv = '0;
    logic [2:0]        rrdy = '0;
    logic [2:0][31:0]  ara = '0;
    logic [2:0]        arr;
    logic [2:0]        rv;
    logic [2:0][31:0]  rd;
    logic [2:0][31:0]  p_addr;
    logic [2:0][31:0]  p_wdata;
    logic [2:0][31:0]  p_rdata;
    logic [2:0][1:0]   p_mask;
    logic [2:0]        p_wen;

    assign bus0.s_arvalid = arv[0];
    assign bus1.s_arvalid = arv[1];
    assign bus3.s_arvalid = arv[2];
    assign bus0.s_araddr  = ara[0];
    assign bus1.s_araddr  = ara[1];
    assign bus3.s_araddr  = ara[2];
    assign bus0.s_rready  = rrdy[0];
    assign bus1.s_rready  = rrdy[1];
    assign bus3.s_rready  = rrdy[2];
    assign arr = {bus3.s_arready, bus1.s_arready, bus0.s_arready};
    assign rv  = {bus3.s_rvalid, bus1.s_rvalid, bus0.s_rvalid};
    assign rd  = {bus3.s_rdata, bus1.s_rdata, bus0.s_rdata};

    assign bus0.s_awaddr = '0;  assign bus0.s_awvalid = 1'b0; assign bus0.s_wdata = '0;
    assign bus0.s_wstrb  = '0;  assign bus0.s_wvalid  = 1'b0; assign bus0.s_bready = 1'b0;
    assign bus3.s_awaddr = '0;  assign bus3.s_awvalid = 1'b0; assign bus3.s_wdata = '0;
    assign bus3.s_wstrb  = '0;  assign bus3.s_wvalid  = 1'b0; assign bus3.s_bready = 1'b0;

    function automatic logic [31:0] fab(input logic [31:0] a);
        return (a == 32'h8000_0020) ? 32'hCAFE_F00D : (a ^ 32'h5A5A_5A5A);
    endfunction

    always_comb begin
        for (int g = 0; g < 3; g++) p_rdata[g] = fab(p_addr[g]);
    end

    axi_lite_perip_bridge #(.READ_LATENCY(0)) u_dut0 (
        .clk(clk), .rst(rst), .s_axi(bus0),
        .perip_addr(p_addr[0]), .perip_wen(p_wen[0]), .perip_mask(p_mask[0]),
        .perip_wdata(p_wdata[0]), .perip_rdata(p_rdata[0])
    );
    axi_lite_perip_bridge #(.READ_LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst), .s_axi(bus1),
        .perip_addr(p_addr[1]), .perip_wen(p_wen[1]), .perip_mask(p_mask[1]),
        .perip_wdata(p_wdata[1]), .perip_rdata(p_rdata[1])
    );
    axi_lite_perip_bridge #(.READ_LATENCY(3)) u_dut3 (
        .clk(clk), .rst(rst), .s_axi(bus3),
        .perip_addr(p_addr[2]), .perip_wen(p_wen[2]), .perip_mask(p_mask[2]),
        .perip_wdata(p_wdata[2]), .perip_rdata(p_rdata[2])
    );

    typedef struct {
        logic [31:0] awaddr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        exp_wen;
        logic [1:0]  exp_mask;
        logic [31:0] exp_wdata;
        logic [1:0]  exp_bresp;
    } wvec_t;

    wvec_t wv [10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Write on the latency-1 instance with bready held high from the start.
    task automatic do_write(input wvec_t v, input int id);
        @(negedge clk);
        bus1.s_awaddr = v.awaddr; bus1.s_wdata = v.wdata; bus1.s_wstrb = v.wstrb;
        bus1.s_awvalid = 1'b1; bus1.s_wvalid = 1'b1; bus1.s_bready = 1'b1;
        #1;
        chk($sformatf("w%0d awready", id), 32'(bus1.s_awready), 32'd1);
        chk($sformatf("w%0d wready", id), 32'(bus1.s_wready), 32'd1);
        chk($sformatf("w%0d arready", id), 32'(arr[1]), 32'd0);
        @(negedge clk);
        bus1.s_awvalid = 1'b0; bus1.s_wvalid = 1'b0;
        chk($sformatf("w%0d wen", id), 32'(p_wen[1]), 32'(v.exp_wen));
        chk($sformatf("w%0d mask", id), 32'(p_mask[1]), 32'(v.exp_mask));
        chk($sformatf("w%0d addr", id), p_addr[1], v.awaddr);
        chk($sformatf("w%0d wdata", id), p_wdata[1], v.exp_wdata);
        chk($sformatf("w%0d bvalid_early", id), 32'(bus1.s_bvalid), 32'd0);
        @(negedge clk);
        chk($sformatf("w%0d bvalid", id), 32'(bus1.s_bvalid), 32'd1);
        chk($sformatf("w%0d bresp", id), 32'(bus1.s_bresp), 32'(v.exp_bresp));
        chk($sformatf("w%0d wen_off", id), 32'(p_wen[1]), 32'd0);
        chk($sformatf("w%0d mask_off", id), 32'(p_mask[1]), 32'd3);
        @(negedge clk);
        bus1.s_bready = 1'b0;
        chk($sformatf("w%0d bvalid_done", id), 32'(bus1.s_bvalid), 32'd0);
    endtask

    task automatic do_read(input int idx, input int rl, input logic [31:0] addr,
                           input logic [31:0] exp, input int bp);
        int n;
        @(negedge clk);
        ara[idx] = addr; arv[idx] = 1'b1; rrdy[idx] = (bp == 0);
        #1;
        chk($sformatf("r%0d arready", rl), 32'(arr[idx]), 32'd1);
        @(negedge clk);
        arv[idx] = 1'b0;
        chk($sformatf("r%0d perip_addr", rl), p_addr[idx], addr);
        n = 1;
        while (!rv[idx] && n < 12) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("r%0d latency", rl), 32'(n), 32'(rl + 2));
        chk($sformatf("r%0d rdata", rl), rd[idx], exp);
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            chk($sformatf("r%0d hold_rvalid", rl), 32'(rv[idx]), 32'd1);
            chk($sformatf("r%0d hold_rdata", rl), rd[idx], exp);
        end
        rrdy[idx] = 1'b1;
        @(negedge clk);
        rrdy[idx] = 1'b0;
        chk($sformatf("r%0d rvalid_done", rl), 32'(rv[idx]), 32'd0);
        chk($sformatf("r%0d idle_arready", rl), 32'(arr[idx]), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        wv[0] = '{32'h8000_0010, 32'hDEAD_BEEF, 4'b1111, 1'b1, 2'b10, 32'hDEAD_BEEF, 2'b00};
        wv[1] = '{32'h8000_0013, 32'hAB00_0000, 4'b1000, 1'b1, 2'b00, 32'h0000_00AB, 2'b00};
        wv[2] = '{32'h8000_0012, 32'h1234_0000, 4'b1100, 1'b1, 2'b01, 32'h0000_1234, 2'b00};
        wv[3] = '{32'h8000_0000, 32'h0000_5500, 4'b0010, 1'b0, 2'b11, 32'h0000_5500, 2'b10};
        wv[4] = '{32'h8000_0021, 32'h0000_CD00, 4'b0010, 1'b1, 2'b00, 32'h0000_00CD, 2'b00};
        wv[5] = '{32'h8000_0022, 32'h00EF_0000, 4'b0100, 1'b1, 2'b00, 32'h0000_00EF, 2'b00};
        wv[6] = '{32'h8000_0004, 32'h0000_5678, 4'b0011, 1'b1, 2'b01, 32'h0000_5678, 2'b00};
        wv[7] = '{32'h8000_0001, 32'h1122_3344, 4'b1111, 1'b0, 2'b11, 32'h0011_2233, 2'b10};
        wv[8] = '{32'h8000_0000, 32'hAABB_CCDD, 4'b1100, 1'b0, 2'b11, 32'hAABB_CCDD, 2'b10};
        wv[9] = '{32'h8000_0008, 32'h0102_0304, 4'b0001, 1'b1, 2'b00, 32'h0102_0304, 2'b00};

        bus1.s_awaddr = '0; bus1.s_wdata = '0; bus1.s_wstrb = '0;
        bus1.s_awvalid = 1'b0; bus1.s_wvalid = 1'b0; bus1.s_bready = 1'b0;

        // Reset values while rst is held.
        #3;
        chk("rst arready", 32'(arr), 32'd0);
        chk("rst awready", 32'(bus1.s_awready), 32'd0);
        chk("rst rvalid", 32'(rv), 32'd0);
        chk("rst bvalid", 32'(bus1.s_bvalid), 32'd0);
        chk("rst wen", 32'(p_wen), 32'd0);
        chk("rst mask", 32'(p_mask[1]), 32'd3);
        chk("rst addr", p_addr[1], 32'd0);
        chk("rst wdata", p_wdata[1], 32'd0);
        chk("rst rdata", rd[1], 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) do_write(wv[i], i);

        do_read(1, 1, 32'h8000_0020, 32'hCAFE_F00D, 3);
        do_read(0, 0, 32'h8000_0020, 32'hCAFE_F00D, 3);
        do_read(2, 3, 32'h8000_0020, 32'hCAFE_F00D, 3);
        do_read(2, 3, 32'h8000_0104, 32'hDA5A_5B5E, 0);
        do_read(1, 1, 32'h8000_0104, 32'hDA5A_5B5E, 0);

        // Simultaneous read and write: write first, read after the write response.
        @(negedge clk);
        bus1.s_awaddr = 32'h8000_0040; bus1.s_wdata = 32'h0BAD_CAFE; bus1.s_wstrb = 4'b1111;
        bus1.s_awvalid = 1'b1; bus1.s_wvalid = 1'b1; bus1.s_bready = 1'b0;
        ara[1] = 32'h8000_0020; arv[1] = 1'b1;
        #1;
        chk("sim awready", 32'(bus1.s_awready), 32'd1);
        chk("sim wready", 32'(bus1.s_wready), 32'd1);
        chk("sim arready", 32'(arr[1]), 32'd0);
        @(negedge clk);
        bus1.s_awvalid = 1'b0; bus1.s_wvalid = 1'b0;
        chk("sim wen", 32'(p_wen[1]), 32'd1);
        chk("sim exec_addr", p_addr[1], 32'h8000_0040);
        chk("sim exec_arready", 32'(arr[1]), 32'd0);
        @(negedge clk);
        chk("sim bvalid", 32'(bus1.s_bvalid), 32'd1);
        chk("sim resp_arready", 32'(arr[1]), 32'd0);
        @(negedge clk);
        chk("sim bvalid_hold", 32'(bus1.s_bvalid), 32'd1);
        bus1.s_bready = 1'b1;
        @(negedge clk);
        bus1.s_bready = 1'b0;
        chk("sim bvalid_done", 32'(bus1.s_bvalid), 32'd0);
        #1;
        chk("sim read_arready", 32'(arr[1]), 32'd1);
        @(negedge clk);
        arv[1] = 1'b0; rrdy[1] = 1'b1;
        chk("sim read_addr", p_addr[1], 32'h8000_0020);
        @(negedge clk);
        chk("sim rvalid_early", 32'(rv[1]), 32'd0);
        @(negedge clk);
        chk("sim rvalid", 32'(rv[1]), 32'd1);
        chk("sim rdata", rd[1], 32'hCAFE_F00D);
        chk("sim rresp", 32'(bus1.s_rresp), 32'd0);
        @(negedge clk);
        rrdy[1] = 1'b0;
        chk("sim rvalid_done", 32'(rv[1]), 32'd0);

        // Reset while the latency-3 instance is in RD_WAIT.
        @(negedge clk);
        ara[2] = 32'h8000_0020; arv[2] = 1'b1;
        @(negedge clk);
        arv[2] = 1'b0;
        chk("rstrd pre_addr", p_addr[2], 32'h8000_0020);
        #2 rst = 1'b1;
        #1;
        chk("rstrd addr", p_addr[2], 32'd0);
        chk("rstrd rvalid", 32'(rv[2]), 32'd0);
        chk("rstrd arready", 32'(arr[2]), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rstrd no_rvalid", 32'(rv[2]), 32'd0);
        end
        chk("rstrd idle_arready", 32'(arr[2]), 32'd1);

        // Reset while the latency-1 instance is in WR_RESP.
        @(negedge clk);
        bus1.s_awaddr = 32'h8000_0030; bus1.s_wdata = 32'h1111_2222; bus1.s_wstrb = 4'b0001;
        bus1.s_awvalid = 1'b1; bus1.s_wvalid = 1'b1; bus1.s_bready = 1'b0;
        @(negedge clk);
        bus1.s_awvalid = 1'b0; bus1.s_wvalid = 1'b0;
        @(negedge clk);
        chk("rstwr pre_bvalid", 32'(bus1.s_bvalid), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rstwr bvalid", 32'(bus1.s_bvalid), 32'd0);
        chk("rstwr addr", p_addr[1], 32'd0);
        chk("rstwr wdata", p_wdata[1], 32'd0);
        chk("rstwr mask", 32'(p_mask[1]), 32'd3);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rstwr no_bvalid", 32'(bus1.s_bvalid), 32'd0);
        end
        do_write(wv[0], 10);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/axi_lite_perip_bridge.md
# axi_lite_perip_bridge

AXI4-Lite responder that terminates the core's data-side AXI4-Lite initiator and drives the flat DRAM/peripheral bus (byte address, single write-enable, 2-bit size mask, fixed-latency read data). Sits between the datapath data port and the DRAM/peripheral fabric on the FPGA build, replacing the hard-wired ready/valid ties. It serves one transaction at a time, converts lane strobes to size masks, right-justifies write data and returns read data after a parameterised latency.

## Interface
- READ_LATENCY, 1, cycles from perip_addr valid to perip_rdata valid (0..7; 0 = combinational)
- clk  in  1  core clock
- rst  in  1  asynchronous reset, active-high
- s_araddr  in  32  read address
- s_arvalid  in  1 / s_arready  out  1  read address handshake
- s_rdata  out  32  read data
- s_rresp  out  2  read response (always 2'b00 OKAY)
- s_rvalid  out  1 / s_rready  in  1  read data handshake
- s_awaddr  in  32  write address
- s_awvalid  in  1 / s_awready  out  1  write address handshake
- s_wdata  in  32  write data, lane-aligned
- s_wstrb  in  4  write byte strobes, lane-aligned
- s_wvalid  in  1 / s_wready  out  1  write data handshake
- s_bresp  out  2  write response (00 OKAY, 10 SLVERR)
- s_bvalid  out  1 / s_bready  in  1  write response handshake
- perip_addr  out  32  byte address to fabric
- perip_wen  out  1  write strobe, one cycle per accepted write
- perip_mask  out  2  00 byte, 01 half, 10 word, 11 no write
- perip_wdata  out  32  right-justified write data
- perip_rdata  in  32  read data from fabric

## Operation
- States: IDLE, RD_WAIT, RD_RESP, WR_EXEC, WR_RESP.
- IDLE: s_awready = s_wready = s_awvalid & s_wvalid (AW and W accepted only together); s_arready = ~(s_awvalid & s_wvalid). Write wins over simultaneous read; read stays pending. All readies 0 outside IDLE.
- Read: on AR handshake register araddr, load counter with READ_LATENCY, go RD_WAIT. RD_WAIT drives perip_addr = registered address; when counter == 0 capture perip_rdata into s_rdata, go RD_RESP; else decrement. RD_RESP: s_rvalid = 1, s_rdata stable until s_rready, then IDLE. No alignment check on reads; perip_rdata returned unshifted.
- Write: on AW/W handshake register address, data, strobes, go WR_EXEC. Legal strobe/offset pairs (off = addr[1:0]): 0001/0, 0010/1, 0100/2, 1000/3 → mask 00; 0011/0, 1100/2 → mask 01; 1111/0 → mask 10. perip_wdata = wdata >> (8*off). WR_EXEC (one cycle): legal → perip_wen = 1, mask as above, bresp latched OKAY; illegal → perip_wen = 0, mask 11, bresp latched SLVERR. Then WR_RESP: s_bvalid = 1 until s_bready, then IDLE.
- perip_mask = 11 and perip_wen = 0 in every state except legal WR_EXEC. perip_addr/perip_wdata hold last values outside active states.
- Counter width 3 bits; READ_LATENCY > 7 unsupported.

## Timing
- Reset (async, immediate): state IDLE, all s_* outputs 0, perip_wen 0, perip_mask 11, perip_addr 0, perip_wdata 0, counter 0. Reset mid-transaction drops it; no response is issued afterwards.
- Read latency: AR handshake at edge T → perip_addr valid in cycle T+1 → perip_rdata sampled at end of cycle T+1+READ_LATENCY → s_rvalid high from cycle T+2+READ_LATENCY (default: 3 cycles after handshake).
- Write latency: handshake at T → perip_wen high exactly in cycle T+1 → s_bvalid high from T+2.
- rvalid/bvalid never deassert before handshake; back-to-back: next transaction accepted in the cycle after the response handshake (IDLE), i.e. ≥1 idle cycle between transactions.
- s_rready or s_bready held high early has no effect before valid.

## Test plan
- Word write: awaddr 0x8000_0010, wdata 0xDEADBEEF, wstrb 1111 → cycle T+1 perip_wen 1, perip_addr 0x8000_0010, mask 10, wdata 0xDEADBEEF; T+2 bvalid, bresp 00.
- Byte write: awaddr 0x8000_0013, wdata 0xAB00_0000, wstrb 1000 → perip_wdata 0x0000_00AB, mask 00, perip_wen one cycle; half write 0x8000_0012/1100/0x1234_0000 → wdata 0x0000_1234, mask 01.
- Illegal strobe: awaddr 0x8000_0000, wstrb 0010 → perip_wen stays 0, mask 11, bresp 10.
- Read with backpressure: READ_LATENCY=1, araddr 0x8000_0020, fabric returns 0xCAFEF00D → rvalid at T+3; rready low 3 cycles → rvalid and rdata 0xCAFEF00D held, return to IDLE after rready; repeat with READ_LATENCY=0 and 3 (rvalid at T+2, T+5).
- Simultaneous AR and AW/W in IDLE → write accepted first (awready/wready 1, arready 0), read accepted after bresp handshake.
- rst asserted in RD_WAIT and in WR_RESP → outputs reach reset values without a clock edge; no stale rvalid/bvalid; following word write completes normally.
